apb_to_xbus_bridge: RTL

//  APB3 slave to Wishbone-classic master bridge that feeds sys_xbus_reg: the RISC-V APB

---
 rtl/apb_to_xbus_bridge.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/apb_to_xbus_bridge.sv
// rtl/apb_to_xbus_bridge.sv - APB3 slave to Wishbone-classic master bridge with window check and ack timeout
module apb_to_xbus_bridge #(
    parameter int                    ADDR_WIDTH        = 32,
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    SELECT_WIDTH      = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] APB_REG_ADDR_BASE = 32'h10000000,
    parameter int                    WINDOW_BYTES      = 256,
    parameter int                    TIMEOUT_CYC       = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [SELECT_WIDTH-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    we_o,
    output logic [SELECT_WIDTH-1:0] sel_o,
    output logic                    stb_o,
    output logic                    cyc_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i
);

    localparam int                    CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_SIZE = ADDR_WIDTH'(WINDOW_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0]   offset;
    logic                    in_window;

    // Subtract first so the upper bound cannot overflow near the top of the address space.
    assign offset    = paddr - APB_REG_ADDR_BASE;
    assign in_window = (paddr >= APB_REG_ADDR_BASE) && (offset < WIN_SIZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                if (psel && !penable) begin
                    adr_d = paddr;
                    dat_d = pwdata;
                    we_d  = pwrite;
                    sel_d = pwrite ? pstrb : {SELECT_WIDTH{1'b1}};
                    if (in_window) begin
                        state_d = S_WB;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            S_WB: begin
                // An ack arriving on the final timeout cycle still completes the transfer.
                if (ack_i) begin
                    rdata_d = we_q ? '0 : dat_i;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                rdata_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign adr_o   = adr_q;
    assign dat_o   = dat_q;
    assign we_o    = we_q;
    assign sel_o   = sel_q;
    assign cyc_o   = (state_q == S_WB);
    assign stb_o   = (state_q == S_WB);
    assign pready  = (state_q == S_RESP);
    assign pslverr = (state_q == S_RESP) && err_q;
    assign prdata  = rdata_q;

endmodule
